// File: rtl/fifo_pkg.sv
// Shared sizing helpers and defaults for the parametrised FIFO slice.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // The extra bit above the index width is the wrap bit. It tells full apart from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DATA_W x DEPTH register array with one synchronous write port and one asynchronous read port.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock first-word-fall-through circular FIFO with thresholds and sticky error flags.
// Defining FIFO_HWM_EN adds the hwm (high-water mark) output.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_TH  = DEPTH - 2,
  parameter int AE_TH  = 2,
  localparam int CW    = ptr_w(DEPTH),
  localparam int AW    = CW - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     space,
  output logic              overflow,
  output logic              underflow,
`ifdef FIFO_HWM_EN
  output logic [CW-1:0]     hwm,
`endif
  input  logic              clr_err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_TH);

  logic [CW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rdata;
  logic              push_acc, pop_acc, ovf_set, udf_set;

  assign count        = wr_ptr - rd_ptr;
  assign space        = DEPTH_C - count;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign dout         = empty ? '0 : rdata;

  // A flush cycle accepts nothing and flags nothing. A pop on a full FIFO frees the slot for a push in the same cycle.
  assign pop_acc  = pop && !empty && !flush;
  assign push_acc = push && (!full || pop_acc) && !flush;
  assign ovf_set  = push && full && !pop && !flush;
  assign udf_set  = pop && empty && !flush;

  fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push_acc),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(din),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + 1'b1;
        if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      end
      // A flag set in the same cycle as clr_err wins over the clear.
      overflow  <= ovf_set | (overflow  & ~clr_err);
      underflow <= udf_set | (underflow & ~clr_err);
    end
  end

`ifdef FIFO_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            hwm <= '0;
    else if (clr_err)      hwm <= '0;
    else if (count > hwm)  hwm <= count;
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (DATA_W=8, DEPTH=16).
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n, flush, push, pop, clr_err;
  logic [7:0] din, dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count, space;
`ifdef FIFO_HWM_EN
  logic [4:0] hwm;
`endif

  int checks = 0;
  int errors = 0;

  param_sync_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .push        (push),
    .din         (din),
    .pop         (pop),
    .dout        (dout),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .space       (space),
    .overflow    (overflow),
    .underflow   (underflow),
`ifdef FIFO_HWM_EN
    .hwm         (hwm),
`endif
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 0; pop = 0; flush = 0; clr_err = 0;
  endtask

  initial begin
    rst_n = 0; idle(); din = 8'h00;
    step(); step();
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_count", count, 0);
    check("rst_space", space, 16);
    check("rst_dout", dout, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    rst_n = 1;
    step();

    // Fill 0x00..0x0F, then drain in order
    for (int i = 0; i < 16; i++) begin
      push = 1; din = 8'(i);
      step();
      check("fill_count", count, i + 1);
      check("fill_af", almost_full, (i + 1 >= 14) ? 1 : 0);
    end
    idle();
    check("fill_full", full, 1);
    check("fill_space", space, 0);
    for (int i = 0; i < 16; i++) begin
      check("drain_dout", dout, i);
      pop = 1;
      step();
    end
    idle();
    check("drain_empty", empty, 1);
    check("drain_dout0", dout, 0);
    check("drain_count", count, 0);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) begin
      push = 1; din = 8'(8'h10 + i);
      step();
    end
    push = 1; pop = 1; din = 8'hAA;
    step();
    idle();
    check("pp_full_count", count, 16);
    check("pp_full_ovf", overflow, 0);
    check("pp_full_full", full, 1);
    for (int i = 0; i < 15; i++) begin
      check("pp_full_seq", dout, 8'h11 + i);
      pop = 1;
      step();
    end
    idle();
    check("pp_full_aa", dout, 8'hAA);
    pop = 1; step(); idle();
    check("pp_full_empty", empty, 1);

    // Overflow, then underflow, then clr_err
    for (int i = 0; i < 16; i++) begin
      push = 1; din = 8'(8'h20 + i);
      step();
    end
    push = 1; din = 8'hEE;
    step(); idle();
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      check("ovf_contents", dout, 8'h20 + i);
      pop = 1;
      step();
    end
    idle();
    pop = 1; step(); idle();
    check("udf_set", underflow, 1);
    check("udf_ovf_held", overflow, 1);
    check("udf_count", count, 0);
    clr_err = 1; step(); idle();
    check("clr_ovf", overflow, 0);
    check("clr_udf", underflow, 0);

    // Write into an empty FIFO shows on dout one cycle later, then 40 cycles at level 3
    push = 1; din = 8'h30;
    step();
    check("lat1_dout", dout, 8'h30);
    check("lat1_empty", empty, 0);
    din = 8'h31; step();
    din = 8'h32; step();
    idle();
    for (int i = 0; i < 40; i++) begin
      check("wrap_dout", dout, 8'h30 + i);
      check("wrap_count", count, 3);
      check("wrap_flags", {full, empty, overflow, underflow}, 4'b0000);
      push = 1; pop = 1; din = 8'(8'h33 + i);
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      check("wrap_tail", dout, 8'h30 + 40 + i);
      pop = 1;
      step();
    end
    idle();
    check("wrap_empty", empty, 1);

    // Flush with push pending and count 5
    for (int i = 0; i < 5; i++) begin
      push = 1; din = 8'(8'h60 + i);
      step();
    end
    idle();
    check("fl_pre_count", count, 5);
    flush = 1; push = 1; din = 8'h77;
    step(); idle();
    check("fl_count", count, 0);
    check("fl_empty", empty, 1);
    check("fl_dout", dout, 0);
    check("fl_flags", {overflow, underflow}, 2'b00);
    pop = 1; step(); idle();
    check("fl_udf_pre", underflow, 1);
    flush = 1; push = 1; pop = 1; din = 8'h78;
    step(); idle();
    check("fl_udf_keep", underflow, 1);
    check("fl_ovf_keep", overflow, 0);
    check("fl_drop", count, 0);
    push = 1; din = 8'h81; step(); idle();
    check("fl_after_push", dout, 8'h81);
    check("fl_after_count", count, 1);

    // Reset asserted in the middle of a burst
    for (int i = 0; i < 4; i++) begin
      push = 1; din = 8'(8'h90 + i);
      step();
    end
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_space", space, 16);
    check("mid_rst_udf", underflow, 0);
    check("mid_rst_ae", almost_empty, 1);
    idle();
    step();
    rst_n = 1;
    step();

`ifdef FIFO_HWM_EN
    check("hwm_rst", hwm, 0);
    for (int i = 0; i < 9; i++) begin
      push = 1; din = 8'(i);
      step();
    end
    idle();
    for (int i = 0; i < 9; i++) begin
      pop = 1;
      step();
    end
    idle();
    check("hwm_peak", hwm, 9);
    for (int i = 0; i < 4; i++) begin
      push = 1; din = 8'(i);
      step();
    end
    idle();
    step();
    check("hwm_hold", hwm, 9);
    clr_err = 1; step(); idle();
    check("hwm_clr", hwm, 0);
    step();
    check("hwm_track", hwm, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
- Parametrised single-clock circular FIFO; the successor to the fixed 8x8 byte queue used in the bootloader receive path.
- Adds configurable width and depth, simultaneous push and pop, almost-full and almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Sits between the UART byte receiver and the bootloader write engine.
- Shares the same first-word-fall-through read model as the existing queue.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AF_TH, DEPTH-2, almost_full asserted when count >= AF_TH.
- AE_TH, 2, almost_empty asserted when count <= AE_TH.
- Derived, not overridable: AW = $clog2(DEPTH); CW = AW+1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of contents
- push  in  1  write request
- din  in  DATA_W  write data
- pop  in  1  read request (acknowledges current dout)
- dout  out  DATA_W  head entry (FWFT)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_TH
- almost_empty  out  1  count <= AE_TH
- count  out  CW  entries held, 0..DEPTH
- space  out  CW  DEPTH - count
- overflow  out  1  sticky: push rejected
- underflow  out  1  sticky: pop rejected
- clr_err  in  1  clears sticky flags

Behaviour:
- Storage and pointers:
  - Pointers wr_ptr and rd_ptr are CW bits wide. The low AW bits index memory; the MSB is the wrap bit.
  - count = wr_ptr - rd_ptr, modulo 2^CW.
  - full when the pointers differ only in the MSB; empty when the pointers are equal.
- Reset (async, rst_n=0): pointers=0, overflow=underflow=0.
  - Outputs then read: empty=1, almost_empty=1, full=0, almost_full=0 (unless AF_TH==0), count=0, space=DEPTH, dout=0.
  - Memory contents are not reset.
- Status outputs: full, empty, almost_*, count, space and dout are combinational from the registered pointers and memory. No status output depends combinationally on push or pop.
- dout:
  - Equals mem[rd_ptr[AW-1:0]] when !empty.
  - Forced to 0 when empty.
  - A word pushed into an empty FIFO appears on dout the cycle after the push edge (latency 1).
- Push accepted when push && (!full || pop_accepted): write mem[wr_ptr], then wr_ptr+1.
- Pop accepted when pop && !empty: rd_ptr+1.
- Simultaneous push and pop:
  - Not empty and not full: both accepted, count unchanged.
  - Full: both accepted, count stays DEPTH, no overflow.
  - Empty: push accepted, pop rejected, underflow set; no same-cycle bypass.
- Error flags:
  - overflow is set by push && full && !pop.
  - underflow is set by pop && empty.
  - Both hold until clr_err=1 at a clock edge.
  - If a set and clr_err coincide, the set wins.
- flush:
  - Sets rd_ptr <= wr_ptr, so the next cycle shows empty.
  - Priority over push and pop in the same cycle; the push is dropped, and no error flags are set by that cycle.
  - Does not clear the sticky flags.
- Wrap-around: pointers wrap naturally modulo 2^CW; no special case.

Optional Feature:
- FIFO_HWM_EN: when defined, adds output port hwm [CW-1:0], the high-water mark.
  - hwm = maximum count observed since reset or the last clr_err.
  - Updated on the cycle after count exceeds it.
  - Reset to 0.
  - flush does not clear it.
- When undefined: port and logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Package fifo_pkg:
  - Function for pointer-width calculation.
  - Localparam defaults DEF_DATA_W=8 and DEF_DEPTH=16.
- Sub-module fifo_mem:
  - Parametrised DATA_W x DEPTH register array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
- Pointer, flag and threshold logic stays in the top module.

Test Plan (DATA_W=8, DEPTH=16 unless stated):
- Reset, then 16 pushes of 0x00..0x0F: full=1, count=16, space=0, almost_full set from count 14. Then 16 pops: dout sequence 0x00..0x0F, empty=1, dout=0.
- Full, then push+pop in the same cycle with din=0xAA: count stays 16, overflow=0. 0xAA is read out as the 16th word after 15 further pops.
- Push with full and no pop: overflow=1, contents unchanged. Pop when empty: underflow=1. clr_err pulse: both return to 0.
- Run 40 push/pop cycles at a 3-deep level: the pointers wrap more than twice, and data order is preserved with no flag glitches.
- flush with push=1 and count=5: next cycle count=0, empty=1; the pushed word is lost and the flags are unchanged. Assert rst_n=0 mid-burst: all outputs take their reset values immediately.
- FIFO_HWM_EN defined: fill to 9 and drain to 0, then hwm=9. Fill to 4: hwm stays 9. Pulse clr_err: hwm reads 0, then tracks the current count.
